// File: rtl/pmem_loader.sv
// Program-memory loader: packs UART bytes (big-endian) into 32-bit words and
// writes them to program memory from address 0, stalling the CPU meanwhile.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | collecting bytes and writing words, cpu_hold asserted
// DONE  | terminator word written, outputs held
// ERROR | memory filled without a terminator, outputs held
module pmem_loader #(
    parameter int          ADDR_W    = 11,
    parameter int          MAX_WORDS = 2 ** ADDR_W,
    parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t              state, state_d;
    logic [1:0]          byte_idx, byte_idx_d;
    logic [23:0]         byte_buf, byte_buf_d;
    logic                mem_we_d, cpu_hold_d, done_d, error_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [31:0]         mem_wdata_d;
    logic [ADDR_W:0]     word_count_d;

    // State and output registers; reset drops the write strobe and the stall at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            byte_buf   <= 24'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_d;
            byte_idx   <= byte_idx_d;
            byte_buf   <= byte_buf_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
            error      <= error_d;
            word_count <= word_count_d;
        end
    end

    // Next-state logic: session start, byte assembly, write strobe and termination.
    always_comb begin
        state_d      = state;
        byte_idx_d   = byte_idx;
        byte_buf_d   = byte_buf;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_hold_d   = cpu_hold;
        done_d       = done;
        error_d      = error;
        word_count_d = word_count;

        case (state)
            RECV: begin
                // Termination is decided while the word is being written, so
                // the last word is always both written and counted.
                if (mem_we) begin
                    mem_addr_d   = mem_addr + ADDR_ONE;
                    word_count_d = word_count + CNT_ONE;
                    if (mem_wdata == END_WORD) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (mem_addr == ADDR_LAST) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end
                // Bytes 0..2 wait in byte_buf; byte 3 completes the word into
                // mem_wdata, leaving byte_buf free for a byte on the write cycle.
                if (rx_valid) begin
                    byte_buf_d = {byte_buf[15:0], rx_data};
                    byte_idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {byte_buf, rx_data};
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d      = RECV;
                    byte_idx_d   = 2'd0;
                    mem_addr_d   = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    cpu_hold_d   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: expected (address, word) pairs are queued
// as words are sent and matched against each mem_we pulse.
module tb_pmem_loader;

    localparam int ADDR_W = 11;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int vectors    = 0;
    int miscompares = 0;
    int we_count   = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;

    pmem_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest queued word and occur while stalled.
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            logic [ADDR_W+31:0] e;
            we_count++;
            check("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e[ADDR_W+31:32]));
                check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
                check("wr_hold", 64'(cpu_hold), 64'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_addr = '0;
        we_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[31-8*i -: 8];
            send_byte(b, gap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        exp_addr = '0;
        tick(3);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        reset = 1'b0;
        tick(2);

        // Bytes in IDLE are ignored; a byte coinciding with start is dropped.
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1);
        check("idle_hold", 64'(cpu_hold), 64'd0);
        rx_data = 8'h99; rx_valid = 1'b1;
        pulse_start();
        rx_valid = 1'b0;
        check("start_hold", 64'(cpu_hold), 64'd1);
        check("start_count", 64'(word_count), 64'd0);

        // Basic load at 16-cycle byte spacing.
        send_word(32'h2001_0005, 15);
        send_word(32'h0000_0000, 15);
        send_word(32'hFFFF_FFFF, 15);
        check("basic_done", 64'(done), 64'd1);
        check("basic_error", 64'(error), 64'd0);
        check("basic_count", 64'(word_count), 64'd3);
        check("basic_hold", 64'(cpu_hold), 64'd0);
        check("basic_addr", 64'(mem_addr), 64'd3);
        check("basic_pulses", 64'(we_count), 64'd3);

        // Bytes in DONE are ignored.
        for (int i = 0; i < 6; i++) send_byte(8'hFF, 2);
        check("doneign_count", 64'(word_count), 64'd3);
        check("doneign_done", 64'(done), 64'd1);

        // Back-to-back bytes, then a start during RECV that must not restart.
        pulse_start();
        check("b2b_clr_done", 64'(done), 64'd0);
        send_word(32'h1112_1314, 0);
        send_word(32'h1516_1718, 0);
        tick(3);
        check("b2b_pulses", 64'(we_count), 64'd2);
        check("b2b_count", 64'(word_count), 64'd2);
        start = 1'b1; tick(1); start = 1'b0;
        tick(2);
        check("recvstart_count", 64'(word_count), 64'd2);
        check("recvstart_hold", 64'(cpu_hold), 64'd1);
        send_word(32'hFFFF_FFFF, 2);
        tick(2);
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_final_count", 64'(word_count), 64'd3);

        // Reset in the middle of a word discards the partial bytes.
        pulse_start();
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        reset = 1'b1;
        #1;
        check("midrst_hold", 64'(cpu_hold), 64'd0);
        check("midrst_we", 64'(mem_we), 64'd0);
        check("midrst_count", 64'(word_count), 64'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        pulse_start();
        send_word(32'h0102_0304, 1);
        send_word(32'hFFFF_FFFF, 1);
        tick(2);
        check("midrst_done", 64'(done), 64'd1);
        check("midrst_final_count", 64'(word_count), 64'd2);

        // Overflow: fill all of memory without a terminator.
        pulse_start();
        for (int i = 0; i < 2048; i++) send_word(32'h0000_0001, 0);
        tick(3);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_done", 64'(done), 64'd0);
        check("ovf_count", 64'(word_count), 64'd2048);
        check("ovf_hold", 64'(cpu_hold), 64'd0);
        check("ovf_addr", 64'(mem_addr), 64'd0);
        check("ovf_pulses", 64'(we_count), 64'd2048);

        // Terminator at the last address resolves to DONE.
        pulse_start();
        check("last_clr_error", 64'(error), 64'd0);
        for (int i = 0; i < 2047; i++) send_word(32'h0000_0001, 0);
        send_word(32'hFFFF_FFFF, 0);
        tick(3);
        check("last_done", 64'(done), 64'd1);
        check("last_error", 64'(error), 64'd0);
        check("last_count", 64'(word_count), 64'd2048);
        check("last_hold", 64'(cpu_hold), 64'd0);

        tick(5);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
